// File: rtl/scroll_message_source.sv
// scroll_message_source: message column ROM scrolled into a 5x7 window; optional blank gap via SCROLL_MSG_GAP_EN
module scroll_message_source #(
  parameter int MSG_LEN = 16,
  parameter int ROWS = 5,
  parameter int COLS = 7
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        step_en,
  input  logic        ch0,
  input  logic        ch1,
  output logic [34:0] win,
  output logic [5:0]  pos,
  output logic        wrap,
  output logic [1:0]  state_o
);
`ifdef SCROLL_MSG_GAP_EN
  localparam int L = MSG_LEN + 7;
`else
  localparam int L = MSG_LEN;
`endif
  localparam logic [6:0] L7 = 7'(L);
  localparam logic [5:0] LAST = 6'(L - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SHOW = 2'd1;
  localparam logic [1:0] SCR_L = 2'd2;
  localparam logic [1:0] SCR_R = 2'd3;

  if (MSG_LEN < COLS || L > 64 || ROWS != 5 || COLS != 7) begin : g_bad_len
    $error("scroll_message_source: MSG_LEN out of supported range");
  end

  logic [1:0]  sync_q, m_q;
  logic [1:0]  state_q, state_d;
  logic [5:0]  pos_q, pos_d;
  logic        wrap_q, wrap_d;
  logic [34:0] win_q, win_d;

  function automatic logic [4:0] rom(input logic [6:0] i);
    logic [4:0] p;
    case (i[3:0])
      4'd0:  p = 5'h1F;
      4'd1:  p = 5'h04;
      4'd2:  p = 5'h1F;
      4'd3:  p = 5'h01;
      4'd4:  p = 5'h11;
      4'd5:  p = 5'h1F;
      4'd6:  p = 5'h11;
      4'd7:  p = 5'h02;
      4'd8:  p = 5'h17;
      4'd9:  p = 5'h08;
      4'd10: p = 5'h0E;
      4'd11: p = 5'h11;
      4'd12: p = 5'h11;
      4'd13: p = 5'h0E;
      4'd14: p = 5'h15;
      default: p = 5'h0A;
    endcase
    return (i < 7'(MSG_LEN)) ? p : 5'd0;
  endfunction

  function automatic logic [34:0] window(input logic [5:0] p);
    logic [34:0] w;
    logic [6:0]  i;
    logic [4:0]  col;
    w = '0;
    for (int c = 0; c < 7; c++) begin
      i = {1'b0, p} + 7'(c);
      i = (i >= L7) ? i - L7 : i;
      col = rom(i);
      for (int r = 0; r < 5; r++) w[r*7+c] = col[r];
    end
    return w;
  endfunction

  // step-gated mode transitions and modular position update
  always_comb begin
    state_d = state_q;
    pos_d = pos_q;
    wrap_d = 1'b0;
    if (step_en) begin
      state_d = (m_q == 2'b11) ? IDLE : (m_q == 2'b00) ? SHOW : (m_q == 2'b01) ? SCR_L : SCR_R;
      pos_d = (state_d == IDLE) ? 6'd0 :
              (state_d == SCR_L) ? ((pos_q == LAST) ? 6'd0 : pos_q + 6'd1) :
              (state_d == SCR_R) ? ((pos_q == 6'd0) ? LAST : pos_q - 6'd1) : pos_q;
      wrap_d = (state_d == SCR_L && pos_q == LAST) || (state_d == SCR_R && pos_q == 6'd0);
    end
  end

  // window follows the registered position, blank while idle
  always_comb begin
    win_d = (state_q == IDLE) ? 35'd0 : window(pos_q);
  end

  // switch synchroniser plus state, position, wrap and window registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '0;
      m_q <= '0;
      state_q <= IDLE;
      pos_q <= '0;
      wrap_q <= 1'b0;
      win_q <= '0;
    end else begin
      sync_q <= {ch1, ch0};
      m_q <= sync_q;
      state_q <= state_d;
      pos_q <= pos_d;
      wrap_q <= wrap_d;
      win_q <= win_d;
    end
  end

  assign win = win_q;
  assign pos = pos_q;
  assign wrap = wrap_q;
  assign state_o = state_q;
endmodule

// File: tb/tb_scroll_message_source.sv
// tb_scroll_message_source: directed and random stimulus against a modular-arithmetic scroll model
module tb_scroll_message_source;
  localparam int MSG_LEN = 16;
`ifdef SCROLL_MSG_GAP_EN
  localparam int L = MSG_LEN + 7;
`else
  localparam int L = MSG_LEN;
`endif
  logic CLK = 1'b0;
  logic RST = 1'b0, step_en = 1'b0, ch0 = 1'b0, ch1 = 1'b0;
  logic [34:0] win;
  logic [5:0]  pos;
  logic        wrap;
  logic [1:0]  state_o;
  int total = 0, passed = 0;
  string phase = "init";
  int ms = 0, mp = 0;
  logic mw = 1'b0;
  logic [34:0] mwin = '0;
  logic [1:0] s1 = '0, s2 = '0;
  logic [4:0] msg [16] = '{5'h1F, 5'h04, 5'h1F, 5'h01, 5'h11, 5'h1F, 5'h11, 5'h02,
                           5'h17, 5'h08, 5'h0E, 5'h11, 5'h11, 5'h0E, 5'h15, 5'h0A};

  scroll_message_source #(.MSG_LEN(MSG_LEN)) dut (
    .CLK(CLK), .RST(RST), .step_en(step_en), .ch0(ch0), .ch1(ch1),
    .win(win), .pos(pos), .wrap(wrap), .state_o(state_o)
  );

  always #5 CLK = ~CLK;

  function automatic logic [34:0] window(input int p);
    logic [34:0] w;
    w = '0;
    for (int c = 0; c < 7; c++) begin
      int i;
      logic [4:0] col;
      i = (p + c) % L;
      col = (i < MSG_LEN) ? msg[i] : 5'd0;
      for (int r = 0; r < 5; r++) w[r*7+c] = col[r];
    end
    return w;
  endfunction

  task automatic model(input logic r, input logic st, input logic [1:0] m);
    logic [34:0] nwin;
    if (r) begin
      ms = 0; mp = 0; mw = 1'b0; mwin = '0; s1 = '0; s2 = '0;
    end else begin
      nwin = (ms == 0) ? 35'd0 : window(mp);
      mw = 1'b0;
      if (st) begin
        if (s2 == 2'b11) begin ms = 0; mp = 0; end
        else if (s2 == 2'b00) ms = 1;
        else if (s2 == 2'b01) begin ms = 2; mw = (mp == L - 1); mp = (mp + 1) % L; end
        else begin ms = 3; mw = (mp == 0); mp = (mp + L - 1) % L; end
      end
      mwin = nwin;
      s2 = s1;
      s1 = m;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
  endtask

  task automatic cyc(input logic r, input logic st, input logic [1:0] m);
    RST = r; step_en = st; {ch1, ch0} = m;
    @(posedge CLK);
    model(r, st, m);
    #1;
    chk("win", 64'(win), 64'(mwin));
    chk("pos", 64'(pos), 64'(mp));
    chk("wrap", 64'(wrap), 64'(mw));
    chk("state", 64'(state_o), 64'(ms));
  endtask

  initial begin
    phase = "reset";
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'(i % 2 == 0), 2'b01);
    phase = "show";
    cyc(1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b1, 2'b00);
    cyc(1'b0, 1'b0, 2'b00);
    chk("show_win_rom0", 64'(win), 64'(window(0)));
    phase = "left";
    cyc(1'b0, 1'b0, 2'b01);
    cyc(1'b0, 1'b0, 2'b01);
    for (int i = 0; i < L; i++) cyc(1'b0, 1'b1, 2'b01);
    chk("left_pos0", 64'(pos), 64'd0);
    chk("left_wrap", 64'(wrap), 64'd1);
    cyc(1'b0, 1'b0, 2'b01);
    chk("left_win_rom0", 64'(win), 64'(window(0)));
    phase = "right";
    cyc(1'b0, 1'b0, 2'b10);
    cyc(1'b0, 1'b0, 2'b10);
    cyc(1'b0, 1'b1, 2'b10);
    chk("right_pos_last", 64'(pos), 64'(L - 1));
    chk("right_wrap", 64'(wrap), 64'd1);
    cyc(1'b0, 1'b0, 2'b10);
    chk("right_wrap_gone", 64'(wrap), 64'd0);
    phase = "clear";
    cyc(1'b0, 1'b0, 2'b11);
    cyc(1'b0, 1'b0, 2'b11);
    cyc(1'b0, 1'b1, 2'b11);
    cyc(1'b0, 1'b0, 2'b01);
    cyc(1'b0, 1'b0, 2'b01);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 2'b01);
    chk("clear_pos5", 64'(pos), 64'd5);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 2'b11);
    chk("clear_nostep", 64'(state_o), 64'd2);
    cyc(1'b0, 1'b1, 2'b11);
    cyc(1'b0, 1'b0, 2'b11);
    chk("clear_win0", 64'(win), 64'd0);
    phase = "sync_hold";
    cyc(1'b0, 1'b0, 2'b01);
    cyc(1'b0, 1'b0, 2'b01);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 2'b01);
    cyc(1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 2'b01);
    cyc(1'b0, 1'b1, 2'b01);
    chk("glitch_pos", 64'(pos), 64'd4);
    cyc(1'b0, 1'b0, 2'b00);
    cyc(1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 2'b00);
    chk("hold_pos", 64'(pos), 64'd4);
    chk("hold_win", 64'(win), 64'(window(4)));
    phase = "random";
    begin
      logic [1:0] m;
      m = 2'b01;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(7) == 0) m = 2'($urandom_range(3));
        cyc(1'($urandom_range(63) == 0), 1'($urandom_range(2) == 0), m);
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
